// File: rtl/enc_pkg.sv
// ============================================================================
// Module      : enc_pkg
// Description : Shared types, constants and helpers for the sequential 4:2
//               priority encoder (encoder_4_2_drain) and its combinational
//               priority-select core (pri_enc_4_2).
// Contents    : state_t          - drain FSM states (IDLE, DRAIN)
//               N_REQ / CODE_W   - request vector width / code width
//               popcount_is_one  - true when exactly one bit is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic popcount_is_one(input logic [N_REQ-1:0] v);
    return (v != '0) && ((v & (v - N_REQ'(1))) == '0);
  endfunction

endpackage : enc_pkg

`default_nettype wire

// File: rtl/pri_enc_4_2.sv
// ============================================================================
// Module      : pri_enc_4_2
// Description : Purely combinational 4:2 priority select. Picks either the
//               highest or the lowest set bit of vec and reports its index
//               together with a one-hot mask of that bit.
// Ports       : vec       in  [3:0] candidate request bits
//               msb_first in        1: highest index wins, 0: lowest wins
//               code      out [1:0] index of the selected bit (0 if none)
//               onehot    out [3:0] mask of the selected bit (0 if none)
//               any       out       at least one bit of vec is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_enc_4_2
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  input  logic              msb_first,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  onehot,
  output logic              any
);

  // Each loop lets the last matching bit overwrite earlier ones, so the scan
  // direction decides which end of the vector has priority.
  always_comb begin
    code   = '0;
    onehot = '0;
    any    = |vec;
    if (msb_first) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          code   = CODE_W'(i);
          onehot = N_REQ'(1) << i;
        end
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) begin
          code   = CODE_W'(i);
          onehot = N_REQ'(1) << i;
        end
      end
    end
  end

endmodule : pri_enc_4_2

`default_nettype wire

// File: rtl/encoder_4_2_drain.sv
// ============================================================================
// Module      : encoder_4_2_drain
// Description : Sequential 4:2 priority encoder. Latches a 4-bit request
//               vector through a valid/ready handshake, then emits the index
//               of every set bit, one per output handshake, in priority order.
//               An all-zero vector is dropped and flagged with zero_err.
// Parameters  : MSB_FIRST  1: emit highest index first, 0: lowest first
// Ports       : clk, rst   clock / synchronous active-high reset
//               in_valid   in       request vector I is valid
//               in_ready   out      block can accept a vector
//               I          in  [3:0] request vector
//               out_valid  out      Y holds a valid code
//               out_ready  in       consumer accepts Y
//               Y          out [1:0] index of current priority pending bit
//               out_last   out      current code is the last pending bit
//               zero_err   out      one-cycle pulse after a zero vector
//               pending    out [3:0] remaining un-emitted request bits
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_4_2_drain
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_REQ-1:0]  I,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] Y,
  output logic              out_last,
  output logic              zero_err,
  output logic [N_REQ-1:0]  pending
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_REQ-1:0]    r_pending;
  logic [N_REQ-1:0]    w_pending_nxt;
  logic                r_zero_err;
  logic                w_zero_err_nxt;

  logic [CODE_W-1:0]   w_code;
  logic [N_REQ-1:0]    w_onehot;
  logic                w_any;
  logic                w_last;
  logic                w_drive;

  pri_enc_4_2 u_pri_enc (
    .vec       (r_pending),
    .msb_first (MSB_FIRST),
    .code      (w_code),
    .onehot    (w_onehot),
    .any       (w_any)
  );

  assign w_last = popcount_is_one(r_pending);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. I is only looked at under in_valid, so an undriven
  // vector while idle never reaches the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (I != '0) begin
            w_pending_nxt = I;
            w_state_nxt   = DRAIN;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (w_last || !w_any) begin
            w_pending_nxt = '0;
            w_state_nxt   = IDLE;
          end else begin
            w_pending_nxt = r_pending & ~w_onehot;
          end
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Reset masks the handshake outputs combinationally so that no
  // beat can be taken at the edge that discards a partially drained vector.
  // ---------------------------------------------------------------------------
  assign w_drive   = (r_state == DRAIN) && !rst;
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = w_drive;
  assign Y         = w_drive ? w_code : '0;
  assign out_last  = w_drive && w_last;
  assign zero_err  = r_zero_err;
  assign pending   = r_pending;

endmodule : encoder_4_2_drain

`default_nettype wire

// File: tb/tb_encoder_4_2_drain.sv
// ============================================================================
// Module      : tb_encoder_4_2_drain
// Description : Self-checking bench for encoder_4_2_drain. Two instances
//               (MSB_FIRST = 1 and 0) share one stimulus stream. A queue of
//               expected codes per instance is the reference; directed
//               scenarios pin literal values, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_4_2_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] I = 4'd0;
  logic       out_ready = 1'b0;

  logic       iready1, ov1, last1, zerr1;
  logic [1:0] y1;
  logic [3:0] pend1;
  logic       iready0, ov0, last0, zerr0;
  logic [1:0] y0;
  logic [3:0] pend0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  encoder_4_2_drain #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready1), .I(I),
    .out_valid(ov1), .out_ready(out_ready), .Y(y1), .out_last(last1),
    .zero_err(zerr1), .pending(pend1)
  );

  encoder_4_2_drain #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready0), .I(I),
    .out_valid(ov0), .out_ready(out_ready), .Y(y0), .out_last(last0),
    .zero_err(zerr0), .pending(pend0)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: list of codes still to be emitted, in emission order.
  // ---------------------------------------------------------------------------
  logic [1:0] q1[$];
  logic [1:0] q0[$];
  bit         m_zerr = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      q0.delete();
      m_zerr = 1'b0;
    end else if (q1.size() == 0) begin
      m_zerr = in_valid && (I == 4'd0);
      if (in_valid && I != 4'd0) begin
        for (int n = 0; n < 4; n++) begin
          if (I[n]) begin
            q0.push_back(2'(n));
            q1.push_front(2'(n));
          end
        end
      end
    end else begin
      m_zerr = 1'b0;
      if (out_ready) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
    end
  end

  function automatic logic [3:0] mask_of(input logic [1:0] q[$]);
    logic [3:0] p = 4'd0;
    foreach (q[k]) p[q[k]] = 1'b1;
    return p;
  endfunction

  // Compare process: every cycle both instances against the reference.
  always @(negedge clk) begin
    if (chk_on) begin
      bit v1, v0;
      v1 = !rst && q1.size() > 0;
      v0 = !rst && q0.size() > 0;
      check("msb in_ready",  int'(iready1), int'(!rst && q1.size() == 0));
      check("msb out_valid", int'(ov1),     int'(v1));
      check("msb Y",         int'(y1),      v1 ? int'(q1[0]) : 0);
      check("msb out_last",  int'(last1),   int'(v1 && q1.size() == 1));
      check("msb zero_err",  int'(zerr1),   int'(m_zerr));
      check("msb pending",   int'(pend1),   int'(mask_of(q1)));
      check("lsb in_ready",  int'(iready0), int'(!rst && q0.size() == 0));
      check("lsb out_valid", int'(ov0),     int'(v0));
      check("lsb Y",         int'(y0),      v0 ? int'(q0[0]) : 0);
      check("lsb out_last",  int'(last0),   int'(v0 && q0.size() == 1));
      check("lsb zero_err",  int'(zerr0),   int'(m_zerr));
      check("lsb pending",   int'(pend0),   int'(mask_of(q0)));
    end
  end

  // Advance one clock; inputs change 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1. Reset / idle
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst in_ready",  int'(iready1), 1);
    check("rst out_valid", int'(ov1), 0);
    check("rst Y",         int'(y1), 0);
    check("rst pending",   int'(pend1), 0);
    tick();

    // 2. Multi-bit drain, highest first: 1011 -> 3,1,0
    I = 4'b1011; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d2 beat0 Y",    int'(y1), 3);
    check("d2 beat0 last", int'(last1), 0);
    tick();
    check("d2 beat1 Y",    int'(y1), 1);
    check("d2 beat1 last", int'(last1), 0);
    tick();
    check("d2 beat2 Y",    int'(y1), 0);
    check("d2 beat2 last", int'(last1), 1);
    tick();
    check("d2 in_ready",   int'(iready1), 1);
    check("d2 out_valid",  int'(ov1), 0);

    // 3. Backpressure, lowest first: 0110 held for 3 stall cycles
    I = 4'b0110; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("d3 stall Y",     int'(y0), 1);
      check("d3 stall valid", int'(ov0), 1);
      check("d3 stall pend",  int'(pend0), 6);
      tick();
    end
    out_ready = 1'b1;
    check("d3 beat0 Y", int'(y0), 1);
    tick();
    check("d3 beat1 Y",    int'(y0), 2);
    check("d3 beat1 last", int'(last0), 1);
    tick();
    check("d3 idle", int'(ov0), 0);

    // 4. Zero vector
    I = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d4 zero_err",  int'(zerr1), 1);
    check("d4 out_valid", int'(ov1), 0);
    check("d4 in_ready",  int'(iready1), 1);
    tick();
    check("d4 zero_err clr", int'(zerr1), 0);

    // 5. Input ignored during drain, accepted afterwards
    I = 4'b1000; in_valid = 1'b1;
    tick();
    I = 4'b1111;
    check("d5 Y",        int'(y1), 3);
    check("d5 last",     int'(last1), 1);
    check("d5 in_ready", int'(iready1), 0);
    tick();
    check("d5 back idle", int'(iready1), 1);
    check("d5 pend clr",  int'(pend1), 0);
    tick();
    in_valid = 1'b0;
    check("d5 pend full", int'(pend1), 15);
    for (int b = 3; b >= 0; b--) begin
      check("d5 seq Y",    int'(y1), b);
      check("d5 seq last", int'(last1), int'(b == 0));
      tick();
    end

    // 6. Reset mid-drain
    I = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d6 first Y", int'(y1), 3);
    tick();
    check("d6 second Y", int'(y1), 2);
    rst = 1'b1;
    tick();
    check("d6 rst valid", int'(ov1), 0);
    check("d6 rst pend",  int'(pend1), 0);
    rst = 1'b0;
    #1;
    check("d6 in_ready", int'(iready1), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("d6 no stale", int'(ov1), 0);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      I         = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_encoder_4_2_drain

`default_nettype wire

// File: doc/encoder_4_2_drain.md
Name: encoder_4_2_drain

Overview:
- Sequential 4:2 priority encoder; the inverse of the team's 2:4 decoder.
- Accepts a 4-bit request vector through a valid/ready handshake and latches it.
- Emits the 2-bit index of every set bit, one per output handshake, in priority order. A final-beat flag marks the last index.
- Sits between request sources and any consumer that needs binary codes, including the 2:4 decoder.

Parameters:
MSB_FIRST  1  1: highest set index is emitted first (3→0); 0: lowest first (0→3)

Ports:
clk        input   1  clock, all state updates on rising edge
rst        input   1  synchronous reset, active high
in_valid   input   1  request vector I is valid
in_ready   output  1  block can accept a vector
I          input   4  request vector, bit n = request n
out_valid  output  1  Y holds a valid code
out_ready  input   1  consumer accepts Y
Y          output  2  encoded index of current highest-priority pending bit
out_last   output  1  qualifies out_valid: current code is the last pending bit
zero_err   output  1  one-cycle pulse: an all-zero vector was accepted
pending    output  4  remaining un-emitted request bits (debug/observability)

Behaviour:
- Reset: synchronous and active-high. While rst=1 at a clk edge:
  - state←IDLE, pending←0, zero_err←0.
  - in_ready=0 and out_valid=0 while rst is high.
  - After release: in_ready=1, out_valid=0, Y=0, out_last=0.
- Reset mid-drain: pending bits are discarded with no further output beats, and the block returns to IDLE.
- States: IDLE, DRAIN.
- IDLE:
  - in_ready=1, out_valid=0.
  - Handshake at edge where in_valid&in_ready:
    - I≠0 → pending←I, state←DRAIN.
    - I=0 → vector dropped, zero_err=1 for exactly the next cycle, stay IDLE.
  - in_valid with in_ready=0 has no effect.
- DRAIN:
  - in_ready=0, out_valid=1.
  - Y = priority index of pending, per MSB_FIRST.
  - out_last=1 iff pending has exactly one bit set.
  - At edge with out_ready=1: clear that bit in pending.
    - If out_last → state←IDLE, pending=0.
  - out_ready=0 → Y, out_last and pending hold stable; out_valid stays high. No retraction.
- Latency:
  - Vector accepted at edge k → first out_valid in cycle k+1.
  - With out_ready held high, a vector with p set bits drains in p cycles.
  - in_ready reasserts in the cycle after the last beat; next accept is at the earliest edge k+p+1.
- Throughput: one code per cycle. No accept/drain overlap (in_ready=0 throughout DRAIN), so simultaneous input and output handshakes cannot occur.
- Y=0 and out_last=0 whenever out_valid=0.
- X on I while in_valid=0 must not propagate.
- Y, out_last and out_valid are combinational from registered state/pending. No combinational path from in_valid/I or out_ready to outputs, except in_ready gating by rst.

Decomposition:
- Package enc_pkg:
  - state enum {IDLE, DRAIN}.
  - Constants N_REQ=4, CODE_W=2.
  - Function popcount_is_one.
- Sub-module pri_enc_4_2 (purely combinational):
  - Inputs: vec[3:0], msb_first.
  - Outputs: code[1:0], onehot[3:0] (mask of selected bit), any.
  - The top clears pending with pending & ~onehot.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then 0 → in_ready=1, out_valid=0, Y=0, pending=0.
2. Multi-bit drain with MSB_FIRST=1: I=4'b1011 accepted, out_ready=1 → Y sequence 3,1,0 on consecutive cycles; out_last=1 only on Y=0; in_ready=1 on the following cycle.
3. Backpressure with MSB_FIRST=0: I=4'b0110, out_ready=0 for 3 cycles, then 1 → Y=1 held stable with out_valid=1 for the 3 stall cycles; then Y=1, Y=2 (out_last=1).
4. Zero vector: I=0 with in_valid=1 → zero_err=1 for exactly one cycle, out_valid stays 0, in_ready stays 1.
5. Ignored input: in_valid=1 with I=4'b1111 during DRAIN of 4'b1000 → ignored; after Y=3 (out_last=1) the block returns to IDLE and the 4'b1111 vector is accepted next (4 beats: 3,2,1,0).
6. Reset mid-operation: accept I=4'b1111, take one beat (Y=3), assert rst → next cycle out_valid=0, pending=0; after release in_ready=1 and no stale codes are emitted.
